axi4lite_buffered_bridge: RTL

- Parametrised successor to the single-transaction AXI4-Lite transactor. Sits between an upstream AXI4-Lite master (s_* side) and a downstream AXI4-Lite slave (m_* side).
- Each of the five channels (AW, W, B, AR, R) gets its own FIFO. Read and write paths run concurrently and independently.
- AW and W are accepted in any order.
- Outstanding transactions per direction are bounded by a parameter.

---
 rtl/axi4lite_buffered_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_buffered_bridge.sv
// AXI4-Lite bridge with a FIFO on each of the five channels and bounded outstanding counts.
// Define AXIL_BRIDGE_ERR_CNT_EN to add saturating error-response counters with a clear input.

module axi4lite_buffered_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign dout  = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[PW-1:0]] <= din;
                wptr              <= wptr + PONE;
            end
            if (pop && !empty) begin
                rptr <= rptr + PONE;
            end
        end
    end
endmodule

module axi4lite_buffered_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]              s_awprot,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [2:0]              s_arprot,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
`ifdef AXIL_BRIDGE_ERR_CNT_EN
    ,
    input  logic                    err_clr,
    output logic [7:0]              err_cnt_wr,
    output logic [7:0]              err_cnt_rd
`endif
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int AE = ADDR_WIDTH + 3;
    localparam int WE = DATA_WIDTH + SW;
    localparam int RE = DATA_WIDTH + 2;
    localparam logic [3:0] MAXO = 4'(MAX_OUTST);

    logic aw_full, aw_empty, aw_push, aw_pop;
    logic w_full, w_empty, w_push, w_pop;
    logic b_full, b_empty, b_push, b_pop;
    logic ar_full, ar_empty, ar_push, ar_pop;
    logic r_full, r_empty, r_push, r_pop;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;

    // Readies depend on registered state only.
    assign s_awready = !aw_full && (wr_cnt < MAXO);
    assign s_wready  = !w_full;
    assign s_arready = !ar_full && (rd_cnt < MAXO);
    assign m_bready  = !b_full;
    assign m_rready  = !r_full;

    assign m_awvalid = !aw_empty;
    assign m_wvalid  = !w_empty;
    assign s_bvalid  = !b_empty;
    assign m_arvalid = !ar_empty;
    assign s_rvalid  = !r_empty;

    assign aw_push = s_awvalid && s_awready;
    assign aw_pop  = m_awvalid && m_awready;
    assign w_push  = s_wvalid && s_wready;
    assign w_pop   = m_wvalid && m_wready;
    assign b_push  = m_bvalid && m_bready;
    assign b_pop   = s_bvalid && s_bready;
    assign ar_push = s_arvalid && s_arready;
    assign ar_pop  = m_arvalid && m_arready;
    assign r_push  = m_rvalid && m_rready;
    assign r_pop   = s_rvalid && s_rready;

    axi4lite_buffered_bridge_fifo #(.WIDTH(AE), .DEPTH(DEPTH)) u_aw (
        .clk(clk), .rst(rst),
        .push(aw_push), .din({s_awprot, s_awaddr}),
        .pop(aw_pop), .dout({m_awprot, m_awaddr}),
        .full(aw_full), .empty(aw_empty)
    );

    axi4lite_buffered_bridge_fifo #(.WIDTH(WE), .DEPTH(DEPTH)) u_w (
        .clk(clk), .rst(rst),
        .push(w_push), .din({s_wstrb, s_wdata}),
        .pop(w_pop), .dout({m_wstrb, m_wdata}),
        .full(w_full), .empty(w_empty)
    );

    axi4lite_buffered_bridge_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst),
        .push(b_push), .din(m_bresp),
        .pop(b_pop), .dout(s_bresp),
        .full(b_full), .empty(b_empty)
    );

    axi4lite_buffered_bridge_fifo #(.WIDTH(AE), .DEPTH(DEPTH)) u_ar (
        .clk(clk), .rst(rst),
        .push(ar_push), .din({s_arprot, s_araddr}),
        .pop(ar_pop), .dout({m_arprot, m_araddr}),
        .full(ar_full), .empty(ar_empty)
    );

    axi4lite_buffered_bridge_fifo #(.WIDTH(RE), .DEPTH(DEPTH)) u_r (
        .clk(clk), .rst(rst),
        .push(r_push), .din({m_rresp, m_rdata}),
        .pop(r_pop), .dout({s_rresp, s_rdata}),
        .full(r_full), .empty(r_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            unique case ({aw_push, b_pop})
                2'b10:   wr_cnt <= wr_cnt + 4'd1;
                2'b01:   wr_cnt <= wr_cnt - 4'd1;
                default: wr_cnt <= wr_cnt;
            endcase
            unique case ({ar_push, r_pop})
                2'b10:   rd_cnt <= rd_cnt + 4'd1;
                2'b01:   rd_cnt <= rd_cnt - 4'd1;
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

`ifdef AXIL_BRIDGE_ERR_CNT_EN
    // Clear takes priority; counts saturate at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_wr <= '0;
            err_cnt_rd <= '0;
        end else if (err_clr) begin
            err_cnt_wr <= '0;
            err_cnt_rd <= '0;
        end else begin
            if (b_pop && s_bresp[1] && (err_cnt_wr != 8'hFF)) begin
                err_cnt_wr <= err_cnt_wr + 8'd1;
            end
            if (r_pop && s_rresp[1] && (err_cnt_rd != 8'hFF)) begin
                err_cnt_rd <= err_cnt_rd + 8'd1;
            end
        end
    end
`endif

    a_wr_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(b_pop && (wr_cnt == 4'd0)));
    a_rd_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(r_pop && (rd_cnt == 4'd0)));
endmodule
